// File: rtl/spi_master_cfg_if.sv
// System-side handshake and SPI bus signals for spi_master_cfg.
// master = the SPI master block, slave = whatever drives/observes it.
interface spi_master_cfg_if #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
    logic              start;
    logic              cpol;
    logic              cpha;
    logic [SS_W-1:0]   ss_sel;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_ready;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  start, cpol, cpha, ss_sel, data_in, miso,
        output data_out, data_ready, busy, sclk, mosi, ss_n
    );

    modport slave (
        output start, cpol, cpha, ss_sel, data_in, miso,
        input  data_out, data_ready, busy, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master, MSB first, one word per transfer,
// with CPOL/CPHA selectable per transfer and registered outputs throughout.
module spi_master_cfg #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_SS  = 4
) (
    input logic              clk,
    input logic              rst,
    spi_master_cfg_if.master bus
);
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_nx;
    logic              cpha_q;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [NUM_SS-1:0] ss_dec;
    logic              wrap;
    logic              leading;
    logic              sample;
    logic              shift;

    // An out-of-range ss_sel matches no line, so the transfer runs unselected.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (bus.ss_sel == SS_W'(i)) ss_dec[i] = 1'b0;
    end

    assign wrap    = (cnt == CNT_MAX);
    assign edge_nx = edge_cnt + 1'b1;
    assign leading = edge_nx[0];
    assign sample  = cpha_q ? !leading : leading;
    // CPHA=0 already presented the MSB at setup, and the final trailing edge has no bit left.
    assign shift   = cpha_q ? leading : (!leading && edge_nx != EDGE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            edge_cnt       <= '0;
            cpha_q         <= 1'b0;
            tx             <= '0;
            rx             <= '0;
            bus.sclk       <= 1'b0;
            bus.mosi       <= 1'b0;
            bus.ss_n       <= '1;
            bus.busy       <= 1'b0;
            bus.data_ready <= 1'b0;
            bus.data_out   <= '0;
        end else begin
            bus.data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sclk <= bus.cpol;
                    if (bus.start) begin
                        state    <= SETUP;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        cpha_q   <= bus.cpha;
                        tx       <= bus.data_in;
                        rx       <= '0;
                        bus.mosi <= bus.cpha ? 1'b0 : bus.data_in[DATA_W-1];
                        bus.ss_n <= ss_dec;
                    end
                end
                // The SETUP wrap produces SCLK edge 1; XFER wraps produce the rest.
                SETUP, XFER: begin
                    cnt <= wrap ? '0 : cnt + 1'b1;
                    if (wrap) begin
                        edge_cnt <= edge_nx;
                        bus.sclk <= ~bus.sclk;
                        if (sample) rx <= {rx[DATA_W-2:0], bus.miso};
                        if (shift) begin
                            bus.mosi <= cpha_q ? tx[DATA_W-1] : tx[DATA_W-2];
                            tx       <= {tx[DATA_W-2:0], 1'b0};
                        end
                        state <= (edge_nx == EDGE_LAST) ? HOLD : XFER;
                    end
                end
                HOLD: begin
                    cnt <= wrap ? '0 : cnt + 1'b1;
                    if (wrap) begin
                        state          <= DONE;
                        bus.ss_n       <= '1;
                        bus.mosi       <= 1'b0;
                        bus.data_out   <= rx;
                        bus.data_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    edge_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: 8-bit/div-2 instance with slave model or
// loopback, plus a 16-bit/div-1 loopback instance.
module tb_spi_master_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic lb0   = 1'b1;
    logic smiso = 1'b0;

    spi_master_cfg_if #(.DATA_W(8),  .NUM_SS(4)) b0 ();
    spi_master_cfg_if #(.DATA_W(16), .NUM_SS(4)) b1 ();

    assign b0.miso = lb0 ? b0.mosi : smiso;
    assign b1.miso = b1.mosi;

    spi_master_cfg #(.DATA_W(8),  .CLK_DIV(2), .NUM_SS(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    spi_master_cfg #(.DATA_W(16), .CLK_DIV(1), .NUM_SS(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int r_edges, r_first, r_last, r_gapbad, r_dr, r_drcnt, r_bf, r_ssf, r_ssl, r_mbad, r_oth;
    logic [7:0] r_dout, r_srx;
    logic r_mset, r_b1, r_send;
    int T0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One transfer on dut0, observed cycle by cycle; n counts cycles after accept.
    task automatic xfer0(input logic pol, input logic pha, input logic [1:0] sel,
                         input logic [7:0] din, input logic [7:0] dmid,
                         input bit lb, input bit hold, input bit pre, input int rst_edge);
        logic [7:0] resp;
        int n, bi, last_e;
        logic ps, pm, pss, act, chg, lead;
        bit rst_on;
        resp = 8'h3C;
        lb0 = lb;
        if (!pre) begin
            b0.cpol = pol; b0.cpha = pha; b0.ss_sel = sel; b0.data_in = din;
            tick();
            chk("idle_sclk", b0.sclk, pol);
            b0.start = 1'b1;
        end
        T0 = cyc;
        r_edges = 0; r_first = -1; r_last = -1; r_gapbad = 0; r_dr = -1; r_drcnt = 0;
        r_bf = -1; r_ssf = -1; r_ssl = -1; r_mbad = 0; r_oth = 0;
        r_dout = 8'h00; r_srx = 8'h00; r_mset = 1'bx; r_b1 = 1'bx; r_send = 1'bx;
        ps = b0.sclk; pm = b0.mosi; pss = 1'b1; bi = 0; last_e = 0; rst_on = 0;
        smiso = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!hold) b0.start = 1'b0;
            n = cyc - T0;
            if (rst_on) begin
                chk("rst_ss_n", b0.ss_n, 4'hF);
                chk("rst_sclk", b0.sclk, 1'b0);
                chk("rst_mosi", b0.mosi, 1'b0);
                chk("rst_busy", b0.busy, 1'b0);
                chk("rst_dr",   b0.data_ready, 1'b0);
                chk("rst_dout", b0.data_out, 8'h00);
                rst = 1'b0;
                break;
            end
            if (n == 10) b0.data_in = dmid;
            if (n == 1) begin r_mset = b0.mosi; r_b1 = b0.busy; end
            act = !b0.ss_n[sel];
            if (act && pss) begin
                bi = 0; r_srx = 8'h00;
                if (!pha) begin smiso = resp[7]; bi = 1; end
            end
            chg = (b0.sclk != ps);
            lead = 1'b0;
            if (chg) begin
                r_edges++;
                if (r_edges == 1) r_first = n;
                else if (n - last_e != 2) r_gapbad++;
                last_e = n; r_last = n;
                lead = (r_edges % 2 == 1);
                if (lead != pha) r_srx = {r_srx[6:0], b0.mosi};
                else if (bi < 8) begin smiso = resp[7-bi]; bi++; end
            end
            if (pha && act && b0.mosi != pm && !(chg && lead)) r_mbad++;
            if (act) begin
                if (r_ssf < 0) r_ssf = n;
                r_ssl = n;
            end
            for (int j = 0; j < 4; j++)
                if (j != int'(sel) && !b0.ss_n[j]) r_oth++;
            if (b0.data_ready) begin r_drcnt++; r_dr = n; r_dout = b0.data_out; end
            if (rst_edge != 0 && r_edges == rst_edge) begin rst = 1'b1; rst_on = 1; end
            ps = b0.sclk; pm = b0.mosi; pss = !act;
            if (!b0.busy && n > 1) begin r_bf = n; r_send = b0.sclk; break; end
        end
    endtask

    initial begin
        int e1, f1, l1, g1, d1, n1, p1, drs;
        logic [15:0] o1;
        b0.start = 0; b0.cpol = 0; b0.cpha = 0; b0.ss_sel = 0; b0.data_in = 0;
        b1.start = 0; b1.cpol = 0; b1.cpha = 0; b1.ss_sel = 0; b1.data_in = 0;
        repeat (3) tick();
        chk("reset_sclk", b0.sclk, 1'b0);
        chk("reset_mosi", b0.mosi, 1'b0);
        chk("reset_ss_n", b0.ss_n, 4'hF);
        chk("reset_busy", b0.busy, 1'b0);
        chk("reset_dr",   b0.data_ready, 1'b0);
        chk("reset_dout", b0.data_out, 8'h00);
        chk("reset_dout1", b1.data_out, 16'h0000);
        rst = 1'b0;
        tick();

        // Mode 0 loopback timing
        xfer0(0, 0, 0, 8'hA5, 8'hA5, 1, 0, 0, 0);
        chk("m0_edges", r_edges, 16);
        chk("m0_first", r_first, 3);
        chk("m0_last",  r_last, 33);
        chk("m0_gap",   r_gapbad, 0);
        chk("m0_dr_at", r_dr, 35);
        chk("m0_drcnt", r_drcnt, 1);
        chk("m0_busy0", r_bf, 36);
        chk("m0_ssf",   r_ssf, 1);
        chk("m0_ssl",   r_ssl, 34);
        chk("m0_oth",   r_oth, 0);
        chk("m0_dout",  r_dout, 8'hA5);

        // All four modes against the slave model
        for (int m = 0; m < 4; m++) begin
            logic [1:0] mv;
            mv = 2'(m);
            xfer0(mv[1], mv[0], 1, 8'hC3, 8'hC3, 0, 0, 0, 0);
            chk($sformatf("mode%0d_slave_rx", m), r_srx, 8'hC3);
            chk($sformatf("mode%0d_dout", m), r_dout, 8'h3C);
            chk($sformatf("mode%0d_setup_mosi", m), r_mset, mv[0] ? 1'b0 : 1'b1);
            chk($sformatf("mode%0d_mosi_lead", m), r_mbad, 0);
            chk($sformatf("mode%0d_end_sclk", m), r_send, mv[1]);
            chk($sformatf("mode%0d_dr_at", m), r_dr, 35);
        end

        // 16-bit, div 1 loopback on dut1
        b1.data_in = 16'hBEEF; b1.start = 1'b1;
        p1 = cyc; e1 = 0; f1 = -1; l1 = -1; g1 = 0; d1 = -1; o1 = 16'h0;
        begin
            logic s1;
            s1 = b1.sclk;
            for (int k = 0; k < 100; k++) begin
                tick();
                b1.start = 1'b0;
                n1 = cyc - p1;
                if (b1.sclk != s1) begin
                    e1++;
                    if (e1 == 1) f1 = n1; else if (n1 - l1 != 1) g1++;
                    l1 = n1;
                end
                s1 = b1.sclk;
                if (b1.data_ready) begin d1 = n1; o1 = b1.data_out; end
                if (!b1.busy && n1 > 1) break;
            end
        end
        chk("w16_edges", e1, 32);
        chk("w16_first", f1, 2);
        chk("w16_last",  l1, 33);
        chk("w16_gap",   g1, 0);
        chk("w16_dr_at", d1, 34);
        chk("w16_dout",  o1, 16'hBEEF);

        // start held high, data_in changes mid-word
        xfer0(0, 0, 0, 8'h5A, 8'h11, 1, 1, 0, 0);
        chk("hold_dout1", r_dout, 8'h5A);
        chk("hold_busy0", r_bf, 36);
        xfer0(0, 0, 0, 8'h11, 8'h11, 1, 0, 1, 0);
        chk("hold_acc",   r_b1, 1'b1);
        chk("hold_dr_at", r_dr, 35);
        chk("hold_dout2", r_dout, 8'h11);

        // Slave-select decode
        xfer0(0, 0, 2, 8'h0F, 8'h0F, 1, 0, 0, 0);
        chk("ss2_first", r_ssf, 1);
        chk("ss2_last",  r_ssl, 34);
        chk("ss2_oth",   r_oth, 0);
        xfer0(0, 0, 3, 8'h0F, 8'h0F, 1, 0, 0, 0);
        chk("ss3_first", r_ssf, 1);
        chk("ss3_last",  r_ssl, 34);
        chk("ss3_oth",   r_oth, 0);

        // Reset at edge 5, no data_ready afterwards, then a clean transfer
        xfer0(1, 0, 0, 8'h77, 8'h77, 1, 0, 0, 5);
        drs = 0;
        repeat (40) begin
            tick();
            if (b0.data_ready) drs++;
        end
        chk("rst_no_dr", drs, 0);
        xfer0(0, 0, 0, 8'h96, 8'h96, 1, 0, 0, 0);
        chk("post_rst_dout", r_dout, 8'h96);
        chk("post_rst_dr",   r_dr, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
